// File: rtl/centroid_calc_pkg.sv
// Shared types and sizing for the centroid measurement front-end and the Kalman stage.
// The coordinate type is common to both; sum width covers a full frame of max coordinates.
package centroid_calc_pkg;

  localparam int DISP_WIDTH = 11;
  localparam int CNT_W      = 20;
  localparam int SUM_W      = DISP_WIDTH + CNT_W;
  localparam int ITER_W     = $clog2(SUM_W + 1);

  typedef logic [DISP_WIDTH-1:0] coord_t;
  typedef logic [CNT_W-1:0]      cnt_t;
  typedef logic [SUM_W-1:0]      sum_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIVIDE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/centroid_calc_if.sv
// Pixel-mask stream in, centroid measurement out. The master side is the pixel
// source / tracker; the slave side is the centroid calculator.
interface centroid_calc_if;
  import centroid_calc_pkg::*;

  logic   pix_valid;
  coord_t pix_x;
  coord_t pix_y;
  logic   pix_hit;
  logic   frame_end;
  coord_t z_x;
  coord_t z_y;
  logic   z_valid;
  logic   busy;
  logic   lost;
  logic   overrun;

  modport master (
    output pix_valid, pix_x, pix_y, pix_hit, frame_end,
    input  z_x, z_y, z_valid, busy, lost, overrun
  );

  modport slave (
    input  pix_valid, pix_x, pix_y, pix_hit, frame_end,
    output z_x, z_y, z_valid, busy, lost, overrun
  );

endinterface

// File: rtl/centroid_calc_seq_divider.sv
// Unsigned restoring divider: SUM_W-bit dividend by CNT_W-bit divisor, one quotient
// bit per cycle; o_done pulses on the edge that produces the final bit.
module centroid_calc_seq_divider
  import centroid_calc_pkg::*;
#(
  parameter int Q_OUT_W = DISP_WIDTH
) (
  input  logic               clk,
  input  logic               areset,
  input  logic               i_start,
  input  sum_t               i_dividend,
  input  cnt_t               i_divisor,
  output logic [Q_OUT_W-1:0] o_quo,
  output logic               o_busy,
  output logic               o_done
);

  sum_t              r_quo;
  cnt_t              r_rem;
  cnt_t              r_div;
  logic [ITER_W-1:0] r_iter;
  logic              r_busy;
  logic              r_done;

  logic [CNT_W:0]    w_rem_sh;
  logic [CNT_W:0]    w_diff;
  logic              w_ge;

  // Remainder never reaches the divisor, so after a successful subtract it fits CNT_W bits.
  assign w_rem_sh = {r_rem, r_quo[SUM_W-1]};
  assign w_ge     = (w_rem_sh >= {1'b0, r_div});
  assign w_diff   = w_rem_sh - {1'b0, r_div};

  // Load on start, then shift-subtract one bit per cycle for SUM_W cycles.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_quo  <= '0;
      r_rem  <= '0;
      r_div  <= '0;
      r_iter <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else if (i_start) begin
      r_quo  <= i_dividend;
      r_rem  <= '0;
      r_div  <= i_divisor;
      r_iter <= ITER_W'(SUM_W);
      r_busy <= 1'b1;
      r_done <= 1'b0;
    end else if (r_busy) begin
      r_quo  <= {r_quo[SUM_W-2:0], w_ge};
      r_rem  <= w_ge ? CNT_W'(w_diff) : CNT_W'(w_rem_sh);
      r_iter <= r_iter - ITER_W'(1);
      r_busy <= (r_iter != ITER_W'(1));
      r_done <= (r_iter == ITER_W'(1));
    end else begin
      r_done <= 1'b0;
    end
  end

  assign o_quo  = r_quo[Q_OUT_W-1:0];
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: rtl/centroid_calc.sv
// Per-frame hit accumulation and centroid division feeding the Kalman tracker.
// The next frame accumulates while the previous frame's sums are being divided.
module centroid_calc
  import centroid_calc_pkg::*;
#(
  parameter int MIN_PIXELS = 16
) (
  input  logic            clk,
  input  logic            areset,
  centroid_calc_if.slave  io_meas
);

  cnt_t   r_cnt;
  sum_t   r_sum_x;
  sum_t   r_sum_y;
  state_t r_state;
  coord_t r_z_x;
  coord_t r_z_y;
  logic   r_z_valid;
  logic   r_lost;
  logic   r_overrun;

  logic   w_hit;
  cnt_t   w_cnt_nxt;
  sum_t   w_sum_x_nxt;
  sum_t   w_sum_y_nxt;
  logic   w_accept;
  logic   w_start;
  coord_t w_quo_x;
  coord_t w_quo_y;
  logic   w_busy_x;
  logic   w_busy_y;
  logic   w_done_x;
  logic   w_done_y;

  // Once the count saturates every register freezes, which keeps the mean intact.
  assign w_hit       = io_meas.pix_valid & io_meas.pix_hit & ~(&r_cnt);
  assign w_cnt_nxt   = r_cnt + CNT_W'(w_hit);
  assign w_sum_x_nxt = r_sum_x + (w_hit ? SUM_W'(io_meas.pix_x) : {SUM_W{1'b0}});
  assign w_sum_y_nxt = r_sum_y + (w_hit ? SUM_W'(io_meas.pix_y) : {SUM_W{1'b0}});

  assign w_accept = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_start  = io_meas.frame_end & w_accept & (w_cnt_nxt >= CNT_W'(MIN_PIXELS));

  // Frame accumulators; frame_end clears them after the snapshot is taken.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_cnt   <= '0;
      r_sum_x <= '0;
      r_sum_y <= '0;
    end else if (io_meas.frame_end) begin
      r_cnt   <= '0;
      r_sum_x <= '0;
      r_sum_y <= '0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_sum_x <= w_sum_x_nxt;
      r_sum_y <= w_sum_y_nxt;
    end
  end

  centroid_calc_seq_divider #(.Q_OUT_W(DISP_WIDTH)) u_div_x (
    .clk        (clk),
    .areset     (areset),
    .i_start    (w_start),
    .i_dividend (w_sum_x_nxt),
    .i_divisor  (w_cnt_nxt),
    .o_quo      (w_quo_x),
    .o_busy     (w_busy_x),
    .o_done     (w_done_x)
  );

  centroid_calc_seq_divider #(.Q_OUT_W(DISP_WIDTH)) u_div_y (
    .clk        (clk),
    .areset     (areset),
    .i_start    (w_start),
    .i_dividend (w_sum_y_nxt),
    .i_divisor  (w_cnt_nxt),
    .o_quo      (w_quo_y),
    .o_busy     (w_busy_y),
    .o_done     (w_done_y)
  );

  // Measurement FSM with registered result and status pulses.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_state   <= ST_IDLE;
      r_z_x     <= '0;
      r_z_y     <= '0;
      r_z_valid <= 1'b0;
      r_lost    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_z_valid <= 1'b0;
      r_lost    <= 1'b0;
      r_overrun <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state <= ST_DIVIDE;
          end else begin
            r_lost <= io_meas.frame_end;
          end
        end
        ST_DIVIDE: begin
          r_overrun <= io_meas.frame_end;
          if (w_done_x & w_done_y) begin
            r_state <= ST_DONE;
          end else begin
            r_state <= ST_DIVIDE;
          end
        end
        ST_DONE: begin
          r_z_x     <= w_quo_x;
          r_z_y     <= w_quo_y;
          r_z_valid <= 1'b1;
          // A frame ending right now is handled exactly as in IDLE.
          if (w_start) begin
            r_state <= ST_DIVIDE;
          end else begin
            r_state <= ST_IDLE;
            r_lost  <= io_meas.frame_end;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign io_meas.z_x     = r_z_x;
  assign io_meas.z_y     = r_z_y;
  assign io_meas.z_valid = r_z_valid;
  assign io_meas.busy    = w_busy_x | w_busy_y;
  assign io_meas.lost    = r_lost;
  assign io_meas.overrun = r_overrun;

endmodule

// File: tb/tb_centroid_calc.sv
// Directed bench for centroid_calc: two instances (MIN_PIXELS=1 and 4) share the
// same pixel stream; expected centroids are hand-computed per frame.
module tb_centroid_calc;
  import centroid_calc_pkg::*;

  logic clk = 1'b0;
  logic areset;
  always #5 clk = ~clk;

  centroid_calc_if bus1 ();
  centroid_calc_if bus4 ();

  centroid_calc #(.MIN_PIXELS(1)) dut1 (.clk(clk), .areset(areset), .io_meas(bus1));
  centroid_calc #(.MIN_PIXELS(4)) dut4 (.clk(clk), .areset(areset), .io_meas(bus4));

  int n_cmp = 0;
  int n_err = 0;
  int n_zv1 = 0;
  int n_zv4 = 0;

  // z_valid pulse counters, sampled on the inactive edge.
  always @(negedge clk) begin
    if (bus1.z_valid) n_zv1 <= n_zv1 + 1;
    if (bus4.z_valid) n_zv4 <= n_zv4 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply one cycle of stimulus to both instances, return 1ns after the sampling edge.
  task automatic drive(input logic v, input int x, input int y, input logic h, input logic fe);
    bus1.pix_valid = v;  bus4.pix_valid = v;
    bus1.pix_x = 11'(x); bus4.pix_x = 11'(x);
    bus1.pix_y = 11'(y); bus4.pix_y = 11'(y);
    bus1.pix_hit = h;    bus4.pix_hit = h;
    bus1.frame_end = fe; bus4.frame_end = fe;
    @(posedge clk); #1;
    bus1.pix_valid = 1'b0; bus4.pix_valid = 1'b0;
    bus1.pix_hit = 1'b0;   bus4.pix_hit = 1'b0;
    bus1.frame_end = 1'b0; bus4.frame_end = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  // Wait (bounded) for a z_valid on the MIN_PIXELS=1 instance and check the result.
  task automatic wait_z(input string tag, input int ex, input int ey,
                        output int lat, output int bcyc);
    lat = -1;
    bcyc = 0;
    for (int k = 0; k < 200; k++) begin
      if (bus1.busy) bcyc++;
      if (bus1.z_valid) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
    end
    chk({tag, "_seen"}, 32'(lat >= 0), 32'd1);
    if (lat >= 0) begin
      chk({tag, "_zx"}, 32'(bus1.z_x), 32'(ex));
      chk({tag, "_zy"}, 32'(bus1.z_y), 32'(ey));
      @(posedge clk); #1;
      chk({tag, "_pulse"}, 32'(bus1.z_valid), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int bcyc;
    int nz;
    int n4;

    areset = 1'b1;
    bus1.pix_valid = 1'b0; bus4.pix_valid = 1'b0;
    bus1.pix_x = '0;       bus4.pix_x = '0;
    bus1.pix_y = '0;       bus4.pix_y = '0;
    bus1.pix_hit = 1'b0;   bus4.pix_hit = 1'b0;
    bus1.frame_end = 1'b0; bus4.frame_end = 1'b0;
    repeat (3) @(posedge clk);
    #1 areset = 1'b0;
    idle(2);

    chk("rst_zx", 32'(bus1.z_x), 32'd0);
    chk("rst_zy", 32'(bus1.z_y), 32'd0);
    chk("rst_zvalid", 32'(bus1.z_valid), 32'd0);
    chk("rst_busy", 32'(bus1.busy), 32'd0);
    chk("rst_lost", 32'(bus1.lost), 32'd0);
    chk("rst_overrun", 32'(bus1.overrun), 32'd0);

    // 1: single hit, latency and busy length
    drive(1'b1, 100, 50, 1'b1, 1'b0);
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    chk("t1_lost4", 32'(bus4.lost), 32'd1);
    wait_z("t1", 100, 50, lat, bcyc);
    chk("t1_latency", 32'(lat), 32'd33);
    chk("t1_busy_cycles", 32'(bcyc), 32'd31);

    // 2: 10x10 block
    for (int y = 300; y < 310; y++)
      for (int x = 200; x < 210; x++)
        drive(1'b1, x, y, 1'b1, 1'b0);
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    wait_z("t2", 204, 304, lat, bcyc);
    idle(2);
    chk("t2_zx4", 32'(bus4.z_x), 32'd204);
    chk("t2_zy4", 32'(bus4.z_y), 32'd304);

    // 3: 3 hits, lost on MIN_PIXELS=4, centroid on MIN_PIXELS=1
    n4 = n_zv4;
    drive(1'b1, 10, 20, 1'b1, 1'b0);
    drive(1'b1, 20, 30, 1'b1, 1'b0);
    drive(1'b1, 30, 40, 1'b1, 1'b0);
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    chk("t3_lost4", 32'(bus4.lost), 32'd1);
    chk("t3_lost1", 32'(bus1.lost), 32'd0);
    idle(1);
    chk("t3_lost4_pulse", 32'(bus4.lost), 32'd0);
    wait_z("t3", 20, 30, lat, bcyc);
    idle(2);
    chk("t3_nozv4", 32'(n_zv4), 32'(n4));
    chk("t3_hold_zx4", 32'(bus4.z_x), 32'd204);
    chk("t3_hold_zy4", 32'(bus4.z_y), 32'd304);

    // 4: frame_end mid-divide drops the second frame
    drive(1'b1, 5, 7, 1'b1, 1'b0);
    drive(1'b1, 6, 8, 1'b1, 1'b0);
    drive(1'b1, 7, 9, 1'b1, 1'b0);
    drive(1'b1, 8, 10, 1'b1, 1'b0);
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, 1000, 1000, 1'b1, 1'b0);
    idle(4);
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    chk("t4_overrun1", 32'(bus1.overrun), 32'd1);
    chk("t4_overrun4", 32'(bus4.overrun), 32'd1);
    chk("t4_busy", 32'(bus1.busy), 32'd1);
    idle(1);
    chk("t4_overrun_pulse", 32'(bus1.overrun), 32'd0);
    wait_z("t4a", 6, 8, lat, bcyc);
    nz = n_zv1;
    idle(40);
    chk("t4_dropped", 32'(n_zv1), 32'(nz));
    drive(1'b1, 300, 400, 1'b1, 1'b0);
    drive(1'b1, 302, 402, 1'b1, 1'b0);
    drive(1'b1, 304, 404, 1'b1, 1'b0);
    drive(1'b1, 306, 406, 1'b1, 1'b0);
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    wait_z("t4c", 303, 403, lat, bcyc);

    // 5: reset mid-divide aborts the frame
    drive(1'b1, 50, 60, 1'b1, 1'b0);
    drive(1'b1, 52, 62, 1'b1, 1'b0);
    drive(1'b1, 54, 64, 1'b1, 1'b0);
    drive(1'b1, 56, 66, 1'b1, 1'b0);
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    idle(10);
    chk("t5_busy_pre", 32'(bus1.busy), 32'd1);
    areset = 1'b1;
    #2;
    chk("t5_rst_zx", 32'(bus1.z_x), 32'd0);
    chk("t5_rst_zy", 32'(bus1.z_y), 32'd0);
    chk("t5_rst_busy", 32'(bus1.busy), 32'd0);
    @(posedge clk); #1;
    areset = 1'b0;
    nz = n_zv1;
    idle(40);
    chk("t5_no_zvalid", 32'(n_zv1), 32'(nz));
    drive(1'b1, 1, 2, 1'b1, 1'b0);
    drive(1'b1, 3, 4, 1'b1, 1'b0);
    drive(1'b1, 5, 6, 1'b1, 1'b0);
    drive(1'b1, 7, 8, 1'b1, 1'b0);
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    wait_z("t5", 4, 5, lat, bcyc);

    // 6: invalid hit ignored, hit coincident with frame_end counted
    drive(1'b0, 0, 0, 1'b1, 1'b0);
    drive(1'b1, 640, 0, 1'b1, 1'b1);
    chk("t6_lost1", 32'(bus1.lost), 32'd0);
    chk("t6_lost4", 32'(bus4.lost), 32'd1);
    wait_z("t6", 640, 0, lat, bcyc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
